// File: rtl/relu_seq_pkg.sv
// Shared definitions for the time-multiplexed vector ReLU sequencer.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package relu_seq_pkg;

  // Legacy-compatible state codes; the enum below takes its values from them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Only the element widths the ReLU cell is characterised for.
  function automatic bit width_legal(input int width);
    return (width == 8) || (width == 16) || (width == 32) || (width == 64);
  endfunction

  // Counters must be able to hold N itself (issue stops at N, never wraps).
  function automatic int ctr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/relu_vec_seq_if.sv
// Producer/consumer vector handshake bundle for relu_vec_seq.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready toward the producer, out_valid/out_ready toward the consumer.
// Signals: in_valid, in_ready, in_data[N*WIDTH], out_valid, out_ready, out_data[N*WIDTH], neg_mask[N].
// Element i of a vector lives at [i*WIDTH +: WIDTH].
interface relu_vec_seq_if #(
  parameter int WIDTH = 32,
  parameter int N     = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       neg_mask;

  // master: the producer/consumer environment; slave: the sequencer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, neg_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, neg_mask
  );
endinterface

// File: rtl/relu_elem.sv
// Single shared ReLU cell: result = 0 when the element MSB is set, else the element.
// Latency: UNIT_LAT cycles (0 = combinational, 1 = one register stage).
// Backpressure: none; the caller only issues when it can take the result.
// Ports: clk, rst_n (sync, active-low), elem_vld/elem_dat in, res_vld/res_dat/res_neg out.
module relu_elem #(
  parameter int WIDTH    = 32,
  parameter int UNIT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             elem_vld,
  input  logic [WIDTH-1:0] elem_dat,
  output logic             res_vld,
  output logic [WIDTH-1:0] res_dat,
  output logic             res_neg
);

  logic             neg_c;
  logic [WIDTH-1:0] res_c;

  // Bit-extraction ReLU: the sign bit alone decides, so the most-negative value also maps to 0.
  assign neg_c = elem_dat[WIDTH-1];
  assign res_c = neg_c ? '0 : elem_dat;

  generate
    if (UNIT_LAT == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign res_vld = elem_vld;
      assign res_dat = res_c;
      assign res_neg = neg_c;
    end else if (UNIT_LAT == 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_vld <= 1'b0;
          res_dat <= '0;
          res_neg <= 1'b0;
        end else begin
          res_vld <= elem_vld;
          res_dat <= res_c;
          res_neg <= neg_c;
        end
      end
    end else begin : g_bad_lat
      $error("relu_elem: UNIT_LAT must be 0 or 1");
    end
  endgenerate

endmodule

// File: rtl/relu_vec_seq.sv
// Vector ReLU sequencer: streams N elements one per cycle through one shared relu_elem.
// Latency: accept edge = cycle 0, out_valid rises at cycle N+UNIT_LAT.
// Backpressure: one vector in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low), io (relu_vec_seq_if.slave: in_* / out_* / neg_mask),
//        busy (high in RUN or DONE).
module relu_vec_seq
  import relu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N        = 8,
  parameter int UNIT_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  relu_vec_seq_if.slave io,
  output logic         busy
);

  localparam int CW = ctr_width(N);

  generate
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("relu_vec_seq: WIDTH must be 8, 16, 32 or 64");
    end
    if (N < 1) begin : g_bad_n
      $error("relu_vec_seq: N must be at least 1");
    end
    if ((UNIT_LAT != 0) && (UNIT_LAT != 1)) begin : g_bad_lat
      $error("relu_vec_seq: UNIT_LAT must be 0 or 1");
    end
  endgenerate

  state_e             state;
  logic [CW-1:0]      issue_idx;
  logic [CW-1:0]      write_idx;
  logic [N*WIDTH-1:0] in_buf;
  logic [N*WIDTH-1:0] out_buf;
  logic [N-1:0]       mask;

  logic               issue_vld;
  logic [WIDTH-1:0]   issue_dat;
  logic               res_vld;
  logic [WIDTH-1:0]   res_dat;
  logic               res_neg;

  assign issue_vld = (state == RUN) && (issue_idx < CW'(N));

  // Element select for the shared unit; out-of-range index presents zero.
  always_comb begin
    issue_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (issue_idx == CW'(i)) begin
        issue_dat = in_buf[i*WIDTH +: WIDTH];
      end
    end
  end

  relu_elem #(
    .WIDTH    (WIDTH),
    .UNIT_LAT (UNIT_LAT)
  ) u_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .elem_vld (issue_vld),
    .elem_dat (issue_dat),
    .res_vld  (res_vld),
    .res_dat  (res_dat),
    .res_neg  (res_neg)
  );

  // Results come back in issue order, so write_idx alone names the destination slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_idx <= '0;
      write_idx <= '0;
      in_buf    <= '0;
      out_buf   <= '0;
      mask      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            in_buf    <= io.in_data;
            out_buf   <= '0;
            mask      <= '0;
            issue_idx <= '0;
            write_idx <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issue_vld) begin
            issue_idx <= issue_idx + 1'b1;
          end
          if (res_vld && (write_idx < CW'(N))) begin
            for (int i = 0; i < N; i++) begin
              if (write_idx == CW'(i)) begin
                out_buf[i*WIDTH +: WIDTH] <= res_dat;
                mask[i]                   <= res_neg;
              end
            end
            write_idx <= write_idx + 1'b1;
            if (write_idx == CW'(N - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.out_data  = out_buf;
  assign io.neg_mask  = mask;
  assign busy         = (state != IDLE);

endmodule

// File: doc/relu_vec_seq.md
Name: relu_vec_seq

Overview:
- Sequencer that time-multiplexes one shared element-wise ReLU unit over an N-element vector. It processes one element per cycle.
- Sits between a vector producer and consumer, both using valid/ready handshakes.
- ReLU semantics match the team's bit-extraction ReLU cell: a two's-complement element with MSB set becomes 0; otherwise it passes through unchanged.
- Lets one comparator be reused N times instead of instantiating N in the circuit.

Parameters:
- WIDTH, 32, element width in bits; legal values 8, 16, 32, 64 only. Any other value is an elaboration error.
- N, 8, elements per vector; N >= 1.
- UNIT_LAT, 1, register stages inside the shared ReLU unit; legal values 0 or 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a vector on in_data.
- in_ready  output  1  block can accept a vector.
- in_data  input  N*WIDTH  packed vector; element i = in_data[i*WIDTH +: WIDTH].
- out_valid  output  1  result vector available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N*WIDTH  packed ReLU results, same packing as in_data.
- neg_mask  output  N  bit i = MSB of input element i (element was negative).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, index and issue counters=0, input/output buffers=0, unit pipeline cleared.
  - Outputs: in_ready=1 (IDLE), out_valid=0, out_data=0, neg_mask=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the input buffer, clear the output buffer and neg_mask, issue_idx=0, write_idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle while issue_idx<N: present element issue_idx to the unit, then issue_idx++.
  - The result for element k is written to the output buffer slot k, and neg_mask[k] is set, exactly UNIT_LAT cycles after issue. With UNIT_LAT=0 the write is in the same cycle.
  - write_idx counts completed writes. When the write for element N-1 occurs, go to DONE at the next edge.
- DONE:
  - out_valid=1; out_data and neg_mask held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE; out_valid=0 the next cycle; out_data keeps its last value.
- Latency: the accept edge is cycle 0; out_valid rises at cycle N+UNIT_LAT.
- No overlap: in_ready=0 throughout RUN and DONE. A new vector is accepted at the earliest one cycle after the output handshake, in IDLE.
- Arithmetic:
  - Result = 0 if element[WIDTH-1]=1, else the element.
  - 0 → 0 with mask bit 0.
  - The most-negative value (e.g. 0x80 for WIDTH=8) → 0 with mask bit 1.
- N=1: single issue, DONE after UNIT_LAT+1 cycles.
- Reset asserted mid-RUN or mid-DONE: the vector is discarded, in-flight unit results are dropped, and all outputs go to their reset values on that edge.
- in_valid or in_data changing while not ready: ignored.
- out_ready asserted outside DONE: ignored.
- Counters are clog2(N+1) bits wide and never wrap: issue stops at N.

Decomposition:
- Package relu_seq_pkg:
  - state enum {IDLE, RUN, DONE};
  - function width_legal(WIDTH) used in the elaboration check;
  - a localparam helper for the counter width.
- Sub-module relu_elem (WIDTH, UNIT_LAT):
  - inputs: valid, element;
  - outputs: valid, result, neg;
  - contents: combinational MSB test and mux, plus an optional register stage with a synchronous active-low reset.
  - This is the single shared resource instance.

Test Plan:
- WIDTH=8, N=4, UNIT_LAT=1, elements {e0=0x7F, e1=0x80, e2=0x00, e3=0xFF} → out elements {0x7F, 0x00, 0x00, 0x00}, neg_mask=4'b1010, out_valid rises exactly 5 cycles after the accept edge.
- Same vector with UNIT_LAT=0 → identical data, out_valid rises 4 cycles after accept. For each slot k, check that the write happens in its issue cycle.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid stays 1, out_data/neg_mask unchanged, in_ready=0. Raise out_ready → state IDLE and in_ready=1 the next cycle.
- Back-to-back: in_valid held high with two different vectors → second accepted only on the first IDLE cycle after the output handshake. Check the second result has no leftover from the first (vector all 0x01 → all 0x01, mask 0).
- Reset mid-RUN: pull rst_n low at issue_idx=2 for one cycle → next cycle out_valid=0, out_data=0, neg_mask=0, in_ready=1. A fresh vector then completes with correct latency.
- WIDTH=64, N=1: inputs 0x8000_0000_0000_0000 → 0 with mask 1; 0x7FFF_FFFF_FFFF_FFFF → unchanged with mask 0.
